// File: rtl/snake_game_ctrl_if.sv
// Signal bundle between the snake game-flow controller and its neighbours:
// keyboard decoder, random-coordinate generator and render/collision datapath.
//
// Apple relocation handshake: apple_req plays the role of "ready" and rand_valid
// the role of "valid". A candidate moves only in a cycle where both are high and
// the candidate is in range. The generator may hold or change rand_x/rand_y
// freely while apple_req is low. Rejected candidates leave apple_req high.
interface snake_game_ctrl_if;
  logic        key_valid;
  logic [2:0]  key_code;
  logic        hit_wall;
  logic        hit_apple;
  logic        rand_valid;
  logic [10:0] rand_x;
  logic [10:0] rand_y;
  logic        apple_req;
  logic [10:0] apple_x;
  logic [10:0] apple_y;
  logic [2:0]  direction;
  logic        step;
  logic        clear;
  logic [1:0]  game_state;
  logic [6:0]  points;

  // Environment side: decoder, random generator, datapath
  modport master (
    output key_valid, key_code, hit_wall, hit_apple, rand_valid, rand_x, rand_y,
    input  apple_req, apple_x, apple_y, direction, step, clear, game_state, points
  );

  // Controller side
  modport slave (
    input  key_valid, key_code, hit_wall, hit_apple, rand_valid, rand_x, rand_y,
    output apple_req, apple_x, apple_y, direction, step, clear, game_state, points
  );
endinterface

// File: rtl/snake_game_ctrl.sv
// Game-flow controller for the VGA snake game: sequences IDLE/PLAY/DEAD/WIN,
// generates the movement tick, filters reversals, scores apples, speeds up
// with score and relocates the apple through the random generator.
// game_state doubles as the debug view of the FSM.
module snake_game_ctrl #(
  parameter int TICK_CYCLES     = 5000000,
  parameter int SPEEDUP_STEP    = 250000,
  parameter int MIN_TICK        = 1000000,
  parameter int WIN_POINTS      = 30,
  parameter int DEAD_HOLD_TICKS = 10
) (
  input logic               clk,
  input logic               rst,
  snake_game_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PLAY = 2'b01,
    S_DEAD = 2'b10,
    S_WIN  = 2'b11
  } state_t;

  localparam int CW = $clog2(TICK_CYCLES + 1);
  localparam int DW = $clog2(DEAD_HOLD_TICKS + 1);

  localparam logic [CW-1:0] TICK_P   = CW'(TICK_CYCLES);
  localparam logic [CW-1:0] STEP_P   = CW'(SPEEDUP_STEP);
  localparam logic [CW-1:0] MIN_P    = CW'(MIN_TICK);
  localparam logic [CW-1:0] ONE_P    = CW'(1);
  localparam logic [DW-1:0] HOLD_END = DW'(DEAD_HOLD_TICKS - 1);
  localparam logic [DW-1:0] ONE_D    = DW'(1);
  localparam logic [6:0]    WIN_P    = 7'(WIN_POINTS);

  localparam logic [2:0]  DIR_HOLD  = 3'b100;
  localparam logic [2:0]  KEY_SPACE = 3'b100;
  localparam logic [10:0] APPLE_HOME = 11'd40;

  state_t        state;
  logic [2:0]    direction;
  logic [2:0]    pending;
  logic          step_q;
  logic          clear_q;
  logic          apple_req_q;
  logic [10:0]   apple_x_q;
  logic [10:0]   apple_y_q;
  logic [6:0]    points_q;
  logic [CW-1:0] period;         // period requested by the score
  logic [CW-1:0] active_period;  // period the running count uses; reloaded on wrap
  logic [CW-1:0] tick_cnt;
  logic [CW-1:0] dead_tick;
  logic [DW-1:0] dead_cnt;
  logic          hit_apple_q;

  logic          key_move;
  logic          key_space;
  logic          key_reversal;
  logic          score;
  logic [6:0]    points_inc;
  logic          win_hit;
  logic          speedup;
  logic [CW-1:0] period_faster;
  logic          rand_ok;
  logic          tick_wrap;
  logic          dead_wrap;
  logic          dead_done;

  // Decoded inputs and next-value helpers
  assign key_move     = bus.key_valid && !bus.key_code[2];
  assign key_space    = bus.key_valid && (bus.key_code == KEY_SPACE);
  // Move codes pair up as w/s and a/d by flipping bit 1
  assign key_reversal = (bus.key_code == (direction ^ 3'b010));
  assign score        = bus.hit_apple && !hit_apple_q && !apple_req_q;
  assign points_inc   = points_q + 7'd1;
  assign win_hit      = (points_inc == WIN_P);
  assign speedup      = ((points_inc % 7'd5) == 7'd0);
  // period never drops below MIN_P, so the subtraction cannot underflow
  assign period_faster = ((period - MIN_P) >= STEP_P) ? (period - STEP_P) : MIN_P;
  assign rand_ok = (bus.rand_x >= 11'd40) && (bus.rand_x <= 11'd760) &&
                   ((bus.rand_x % 11'd20) == 11'd0) &&
                   (bus.rand_y >= 11'd40) && (bus.rand_y <= 11'd560) &&
                   ((bus.rand_y % 11'd20) == 11'd0);
  assign tick_wrap = (tick_cnt == (active_period - ONE_P));
  assign dead_wrap = (dead_tick == (TICK_P - ONE_P));
  assign dead_done = dead_wrap && (dead_cnt == HOLD_END);

  // Game FSM with all outputs registered
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      direction     <= DIR_HOLD;
      pending       <= 3'b000;
      step_q        <= 1'b0;
      clear_q       <= 1'b0;
      apple_req_q   <= 1'b0;
      apple_x_q     <= APPLE_HOME;
      apple_y_q     <= APPLE_HOME;
      points_q      <= 7'd0;
      period        <= TICK_P;
      active_period <= TICK_P;
      tick_cnt      <= '0;
      dead_tick     <= '0;
      dead_cnt      <= '0;
      hit_apple_q   <= 1'b0;
    end else begin
      hit_apple_q <= bus.hit_apple;
      step_q      <= 1'b0;
      clear_q     <= 1'b0;
      case (state)
        S_IDLE: begin
          direction <= DIR_HOLD;
          tick_cnt  <= '0;
          if (key_move) begin
            state         <= S_PLAY;
            direction     <= bus.key_code;
            pending       <= bus.key_code;
            clear_q       <= 1'b1;
            active_period <= period;
          end
        end
        S_PLAY: begin
          if (bus.hit_wall) begin
            state       <= S_DEAD;
            direction   <= DIR_HOLD;
            apple_req_q <= 1'b0;
            tick_cnt    <= '0;
            dead_tick   <= '0;
            dead_cnt    <= '0;
          end else if (key_space) begin
            state       <= S_IDLE;
            direction   <= DIR_HOLD;
            clear_q     <= 1'b1;
            points_q    <= 7'd0;
            period      <= TICK_P;
            apple_req_q <= 1'b0;
            tick_cnt    <= '0;
          end else if (score && win_hit) begin
            // Winning apple freezes the snake; no step on the way out
            state       <= S_WIN;
            points_q    <= points_inc;
            apple_req_q <= 1'b0;
            tick_cnt    <= '0;
          end else begin
            if (tick_wrap) begin
              tick_cnt      <= '0;
              step_q        <= 1'b1;
              direction     <= pending;
              active_period <= period;
            end else begin
              tick_cnt <= tick_cnt + ONE_P;
            end
            if (key_move && !key_reversal) begin
              pending <= bus.key_code;
            end
            if (apple_req_q && bus.rand_valid && rand_ok) begin
              apple_x_q   <= bus.rand_x;
              apple_y_q   <= bus.rand_y;
              apple_req_q <= 1'b0;
            end
            if (score) begin
              points_q    <= points_inc;
              apple_req_q <= 1'b1;
              if (speedup) begin
                period <= period_faster;
              end
            end
          end
        end
        S_DEAD: begin
          direction <= DIR_HOLD;
          // Speed is kept across a death; only a deliberate restart resets it
          if (key_space || dead_done) begin
            state    <= S_IDLE;
            clear_q  <= 1'b1;
            points_q <= 7'd0;
          end else if (dead_wrap) begin
            dead_tick <= '0;
            dead_cnt  <= dead_cnt + ONE_D;
          end else begin
            dead_tick <= dead_tick + ONE_P;
          end
        end
        S_WIN: begin
          if (key_space) begin
            state     <= S_IDLE;
            direction <= DIR_HOLD;
            clear_q   <= 1'b1;
            points_q  <= 7'd0;
            period    <= TICK_P;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.game_state = state;
  assign bus.direction  = direction;
  assign bus.step       = step_q;
  assign bus.clear      = clear_q;
  assign bus.apple_req  = apple_req_q;
  assign bus.apple_x    = apple_x_q;
  assign bus.apple_y    = apple_y_q;
  assign bus.points     = points_q;

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Scoreboard bench for snake_game_ctrl. The driver pushes hand-computed output
// snapshots (with the cycle they must appear in) into exp_q; the monitor pops
// one whenever the DUT pulses step/clear or changes any other output.
module tb_snake_game_ctrl;

  localparam int W = 53;

  logic clk;
  logic rst;
  int   cyc = 0;

  snake_game_ctrl_if bus();

  snake_game_ctrl #(
    .TICK_CYCLES     (10),
    .SPEEDUP_STEP    (2),
    .MIN_TICK        (4),
    .WIN_POINTS      (6),
    .DEAD_HOLD_TICKS (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  logic [W-1:0] exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  bit  mon_on   = 0;
  bit  end_req  = 0;
  bit  end_done = 0;

  logic [1:0]  e_state;
  logic [6:0]  e_pts;
  logic        e_req;
  logic [10:0] e_ax;
  logic [10:0] e_ay;
  logic [2:0]  e_dir;

  // Layout: cyc[52:37] step[36] clear[35] state[34:33] pts[32:26] req[25] ax[24:14] ay[13:3] dir[2:0]
  function automatic logic [W-1:0] pack(input logic [15:0] c, input logic s, input logic cl,
                                        input logic [1:0] st, input logic [6:0] p, input logic r,
                                        input logic [10:0] x, input logic [10:0] y,
                                        input logic [2:0] d);
    return {c, s, cl, st, p, r, x, y, d};
  endfunction

  function automatic string fmt(input logic [W-1:0] v);
    return $sformatf("cyc=%0d step=%0b clear=%0b state=%0d points=%0d req=%0b apple=(%0d,%0d) dir=%03b",
                     v[52:37], v[36], v[35], v[34:33], v[32:26], v[25], v[24:14], v[13:3], v[2:0]);
  endfunction

  task automatic ev(input int at, input logic s, input logic cl);
    exp_q.push_back(pack(16'(at), s, cl, e_state, e_pts, e_req, e_ax, e_ay, e_dir));
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] obs;
  logic [W-1:0] exp_v;
  logic [34:0]  prev_fields;
  bit           first = 1;

  always @(negedge clk) begin
    if (mon_on && !end_done) begin
      obs = pack(16'(cyc), bus.step, bus.clear, bus.game_state, bus.points, bus.apple_req,
                 bus.apple_x, bus.apple_y, bus.direction);
      if (first || obs[36] || obs[35] || (obs[34:0] != prev_fields)) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event got: %s required: no event", fmt(obs));
        end else begin
          exp_v = exp_q.pop_front();
          if (exp_v !== obs) begin
            failures++;
            $display("FAIL event_%0d got: %s required: %s", checks, fmt(obs), fmt(exp_v));
          end
        end
      end
      first       = 0;
      prev_fields = obs[34:0];
    end
    if (end_req && !end_done) begin
      checks++;
      if (exp_q.size() != 0) begin
        failures++;
        $display("FAIL missing_events got: %0d still pending, next %s required: 0",
                 exp_q.size(), fmt(exp_q[0]));
      end
      end_done = 1;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic at_cycle(input int t);
    while (cyc < t) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic key(input int t, input logic [2:0] code);
    at_cycle(t);
    bus.key_valid = 1'b1;
    bus.key_code  = code;
    at_cycle(t + 1);
    bus.key_valid = 1'b0;
    bus.key_code  = 3'b000;
  endtask

  // Scoring edge, an extra edge while the request is up, a rejected and an accepted candidate
  task automatic apple(input int t, input logic [10:0] bx, input logic [10:0] by,
                       input logic [10:0] gx, input logic [10:0] gy);
    at_cycle(t);
    bus.hit_apple = 1'b1;
    at_cycle(t + 1);
    bus.hit_apple = 1'b0;
    at_cycle(t + 2);
    bus.hit_apple  = 1'b1;
    bus.rand_valid = 1'b1;
    bus.rand_x     = bx;
    bus.rand_y     = by;
    at_cycle(t + 3);
    bus.hit_apple = 1'b0;
    bus.rand_x    = gx;
    bus.rand_y    = gy;
    at_cycle(t + 4);
    bus.rand_valid = 1'b0;
  endtask

  // ---------------- expected events + stimulus ----------------
  initial begin
    rst            = 1'b1;
    bus.key_valid  = 1'b0;
    bus.key_code   = 3'b000;
    bus.hit_wall   = 1'b0;
    bus.hit_apple  = 1'b0;
    bus.rand_valid = 1'b0;
    bus.rand_x     = 11'd0;
    bus.rand_y     = 11'd0;

    // Reset values
    e_state = 2'd0; e_pts = 7'd0; e_req = 1'b0; e_ax = 11'd40; e_ay = 11'd40; e_dir = 3'b100;
    ev(4, 0, 0);
    // Key d at 10: PLAY + clear at 11, steps every 10 cycles from 21
    e_state = 2'd1; e_dir = 3'b000; ev(11, 0, 1);
    ev(21, 1, 0);
    // a rejected (reverse of right), w accepted, committed on the step
    e_dir = 3'b011; ev(31, 1, 0);
    // Apple 1: (35,40) rejected, (100,200) accepted
    e_pts = 7'd1; e_req = 1'b1; ev(34, 0, 0);
    e_req = 1'b0; e_ax = 11'd100; e_ay = 11'd200; ev(37, 0, 0);
    ev(41, 1, 0);
    e_pts = 7'd2; e_req = 1'b1; ev(44, 0, 0);
    e_req = 1'b0; e_ax = 11'd760; e_ay = 11'd560; ev(47, 0, 0);
    ev(51, 1, 0);
    e_pts = 7'd3; e_req = 1'b1; ev(54, 0, 0);
    e_req = 1'b0; e_ax = 11'd40; e_ay = 11'd40; ev(57, 0, 0);
    ev(61, 1, 0);
    e_pts = 7'd4; e_req = 1'b1; ev(64, 0, 0);
    e_req = 1'b0; e_ax = 11'd400; e_ay = 11'd300; ev(67, 0, 0);
    ev(71, 1, 0);
    // Fifth point: period 10 -> 8, effective after the running period
    e_pts = 7'd5; e_req = 1'b1; ev(74, 0, 0);
    e_req = 1'b0; e_ax = 11'd200; e_ay = 11'd100; ev(77, 0, 0);
    ev(81, 1, 0);
    ev(89, 1, 0);
    ev(97, 1, 0);
    // Sixth point wins; space returns to IDLE
    e_state = 2'd3; e_pts = 7'd6; ev(100, 0, 0);
    e_state = 2'd0; e_pts = 7'd0; e_dir = 3'b100; ev(106, 0, 1);
    // New game heading down, period back to 10
    e_state = 2'd1; e_dir = 3'b001; ev(111, 0, 1);
    e_pts = 7'd1; e_req = 1'b1; ev(114, 0, 0);
    e_req = 1'b0; e_ax = 11'd300; e_ay = 11'd400; ev(117, 0, 0);
    ev(121, 1, 0);
    e_dir = 3'b010; ev(131, 1, 0);
    // Wall + apple edge + space together: DEAD, points kept
    e_state = 2'd2; e_dir = 3'b100; ev(134, 0, 0);
    e_state = 2'd0; e_pts = 7'd0; ev(164, 0, 1);
    // Reset in the middle of a game
    e_state = 2'd1; e_dir = 3'b000; ev(171, 0, 1);
    e_pts = 7'd1; e_req = 1'b1; ev(174, 0, 0);
    ev(181, 1, 0);
    e_state = 2'd0; e_pts = 7'd0; e_req = 1'b0; e_ax = 11'd40; e_ay = 11'd40; e_dir = 3'b100;
    ev(189, 0, 0);

    // Stimulus
    at_cycle(4);
    rst    = 1'b0;
    mon_on = 1'b1;
    key(10, 3'b000);
    key(23, 3'b010);
    key(25, 3'b011);
    apple(33, 11'd35, 11'd40, 11'd100, 11'd200);
    apple(43, 11'd770, 11'd40, 11'd760, 11'd560);
    apple(53, 11'd40, 11'd580, 11'd40, 11'd40);
    apple(63, 11'd50, 11'd60, 11'd400, 11'd300);
    apple(73, 11'd60, 11'd30, 11'd200, 11'd100);
    at_cycle(99);
    bus.hit_apple = 1'b1;
    at_cycle(100);
    bus.hit_apple = 1'b0;
    key(105, 3'b100);
    key(110, 3'b001);
    apple(113, 11'd760, 11'd580, 11'd300, 11'd400);
    key(123, 3'b011);
    key(125, 3'b010);
    at_cycle(133);
    bus.hit_wall  = 1'b1;
    bus.hit_apple = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_code  = 3'b100;
    at_cycle(134);
    bus.hit_wall  = 1'b0;
    bus.hit_apple = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 3'b000;
    key(170, 3'b000);
    at_cycle(173);
    bus.hit_apple = 1'b1;
    at_cycle(174);
    bus.hit_apple = 1'b0;
    at_cycle(188);
    rst = 1'b1;
    at_cycle(195);
    rst = 1'b0;
    at_cycle(205);
    end_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
